// File: rtl/mux3_rr_arbiter_if.sv
// Handshake bundle for mux3_rr_arbiter: three producer valid/ready/data lanes,
// one registered consumer channel, and the observable mux select.
interface mux3_rr_arbiter_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  in0_valid;
   logic                  in1_valid;
   logic                  in2_valid;
   logic [DATA_WIDTH-1:0] in0_data;
   logic [DATA_WIDTH-1:0] in1_data;
   logic [DATA_WIDTH-1:0] in2_data;
   logic                  in0_ready;
   logic                  in1_ready;
   logic                  in2_ready;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_data;
   logic [1:0]            out_src;
   logic                  out_ready;
   logic [1:0]            sel;

   // The arbiter itself sits on the slave side of this bundle.
   modport slave (
      input  in0_valid, in1_valid, in2_valid,
      input  in0_data, in1_data, in2_data,
      input  out_ready,
      output in0_ready, in1_ready, in2_ready,
      output out_valid, out_data, out_src, sel
   );

   // Producers and consumer together form the master side.
   modport master (
      output in0_valid, in1_valid, in2_valid,
      output in0_data, in1_data, in2_data,
      output out_ready,
      input  in0_ready, in1_ready, in2_ready,
      input  out_valid, out_data, out_src, sel
   );
endinterface

// File: rtl/mux3_rr_arbiter.sv
// Three-requester round-robin arbiter feeding one registered valid/ready output.
// Define MUX3_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority 0 > 1 > 2.
module mux3_rr_arbiter #(
   parameter int DATA_WIDTH = 32
) (
   input logic                clk,
   input logic                rst_n,
   mux3_rr_arbiter_if.slave   bus
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t                state;
   logic [1:0]            last_grant;
   logic [1:0]            pick;
   logic [2:0]            valids;
   logic                  any_valid;
   logic                  load_en;
   logic                  load;
   logic [DATA_WIDTH-1:0] mux_data;
   logic [DATA_WIDTH-1:0] out_data_q;
   logic [1:0]            out_src_q;

   assign valids    = {bus.in2_valid, bus.in1_valid, bus.in0_valid};
   assign any_valid = |valids;

   // Returns the first of a, b, c whose valid is set; c when none are.
   function automatic logic [1:0] first_valid(input logic [2:0] v,
                                              input logic [1:0] a,
                                              input logic [1:0] b,
                                              input logic [1:0] c);
      logic [1:0] r;
      if (v[a])
         r = a;
      else if (v[b])
         r = b;
      else
         r = c;
      return r;
   endfunction

`ifdef MUX3_ARB_FIXED_PRIO_EN
   // last_grant is still tracked so both builds share one register set.
   logic unused_last_grant;
   assign unused_last_grant = ^last_grant;

   always_comb begin
      pick = first_valid(valids, 2'd0, 2'd1, 2'd2);
   end
`else
   // Search starts just after the last winner and ends on the last winner itself.
   always_comb begin
      pick = 2'd0;
      case (last_grant)
         2'd0:    pick = first_valid(valids, 2'd1, 2'd2, 2'd0);
         2'd1:    pick = first_valid(valids, 2'd2, 2'd0, 2'd1);
         default: pick = first_valid(valids, 2'd0, 2'd1, 2'd2);
      endcase
   end
`endif

   always_comb begin
      mux_data = bus.in0_data;
      case (pick)
         2'd1:    mux_data = bus.in1_data;
         2'd2:    mux_data = bus.in2_data;
         default: mux_data = bus.in0_data;
      endcase
   end

   // Readys are forced low while reset is held so no word is acknowledged then.
   assign load_en = (state == EMPTY) || bus.out_ready;
   assign load    = rst_n && load_en && any_valid;

   assign bus.in0_ready = load && (pick == 2'd0);
   assign bus.in1_ready = load && (pick == 2'd1);
   assign bus.in2_ready = load && (pick == 2'd2);
   assign bus.sel       = pick;

   assign bus.out_valid = (state == FULL);
   assign bus.out_data  = out_data_q;
   assign bus.out_src   = out_src_q;

   // A load always wins over a drain, which gives one transfer per cycle when full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= EMPTY;
         out_data_q <= '0;
         out_src_q  <= 2'd0;
         last_grant <= 2'd2;
      end else if (load) begin
         state      <= FULL;
         out_data_q <= mux_data;
         out_src_q  <= pick;
         last_grant <= pick;
      end else if ((state == FULL) && bus.out_ready) begin
         state <= EMPTY;
      end
   end

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Self-checking bench for mux3_rr_arbiter: a per-cycle reference model plus
// directed scenarios with hand-computed expectations.
module tb_mux3_rr_arbiter;

   logic clk;
   logic rst_n;
   int   pass_count;
   int   check_count;

   mux3_rr_arbiter_if #(.DATA_WIDTH(32)) bus ();

   mux3_rr_arbiter #(.DATA_WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state: what the output register must hold.
   logic        m_valid;
   logic [31:0] m_data;
   int          m_src;
   int          m_last;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      check_count++;
      if (actual === expected)
         pass_count++;
      else
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
   endtask

   task automatic applyStimulus(input logic v0, input logic v1, input logic v2,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic ordy);
      @(posedge clk);
      #1;
      bus.in0_valid = v0;
      bus.in1_valid = v1;
      bus.in2_valid = v2;
      bus.in0_data  = d0;
      bus.in1_data  = d1;
      bus.in2_data  = d2;
      bus.out_ready = ordy;
   endtask

   // Index of the requester that must win now, or -1 when nobody asks.
   function automatic int model_pick();
      logic [2:0] v;
      int idx;
      v = {bus.in2_valid, bus.in1_valid, bus.in0_valid};
`ifdef MUX3_ARB_FIXED_PRIO_EN
      for (int k = 0; k < 3; k++)
         if (v[k]) return k;
`else
      for (int k = 1; k <= 3; k++) begin
         idx = (m_last + k) % 3;
         if (v[idx]) return idx;
      end
`endif
      return -1;
   endfunction

   function automatic logic [31:0] input_word(input int idx);
      if (idx == 0) return bus.in0_data;
      if (idx == 1) return bus.in1_data;
      return bus.in2_data;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      int p;
      if (!rst_n) begin
         m_valid = 1'b0;
         m_data  = 32'd0;
         m_src   = 0;
         m_last  = 2;
      end else begin
         p = model_pick();
         if (p >= 0 && (!m_valid || bus.out_ready)) begin
            m_valid = 1'b1;
            m_data  = input_word(p);
            m_src   = p;
            m_last  = p;
         end else if (m_valid && bus.out_ready) begin
            m_valid = 1'b0;
         end
      end
   end

   // Every falling edge: outputs and readys against the model.
   always @(negedge clk) begin
      int p;
      logic grant_ok;
      p = model_pick();
      grant_ok = rst_n && (p >= 0) && (!m_valid || bus.out_ready);
      checkOutput("model_out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
      checkOutput("model_out_data", bus.out_data, m_data);
      checkOutput("model_out_src", {30'd0, bus.out_src}, m_src);
      checkOutput("model_in0_ready", {31'd0, bus.in0_ready}, {31'd0, grant_ok && p == 0});
      checkOutput("model_in1_ready", {31'd0, bus.in1_ready}, {31'd0, grant_ok && p == 1});
      checkOutput("model_in2_ready", {31'd0, bus.in2_ready}, {31'd0, grant_ok && p == 2});
      if (rst_n && p >= 0)
         checkOutput("model_sel", {30'd0, bus.sel}, p);
   end

   initial begin
      logic [31:0] rot_data [3];
      rot_data[0] = 32'hA0;
      rot_data[1] = 32'hB1;
      rot_data[2] = 32'hC2;
      pass_count  = 0;
      check_count = 0;

      rst_n         = 1'b0;
      bus.in0_valid = 1'b1;
      bus.in1_valid = 1'b1;
      bus.in2_valid = 1'b1;
      bus.in0_data  = 32'hA0;
      bus.in1_data  = 32'hB1;
      bus.in2_data  = 32'hC2;
      bus.out_ready = 1'b1;

      // Reset held with every requester asking.
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      checkOutput("rst_out_data", bus.out_data, 32'd0);
      checkOutput("rst_out_src", {30'd0, bus.out_src}, 32'd0);
      checkOutput("rst_readys", {29'd0, bus.in2_ready, bus.in1_ready, bus.in0_ready}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("first_grant", {29'd0, bus.in2_ready, bus.in1_ready, bus.in0_ready}, 32'b001);

`ifdef MUX3_ARB_FIXED_PRIO_EN
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput($sformatf("fixed_src_%0d", i), {30'd0, bus.out_src}, 32'd0);
         checkOutput($sformatf("fixed_in1_ready_%0d", i), {31'd0, bus.in1_ready}, 32'd0);
         checkOutput($sformatf("fixed_in2_ready_%0d", i), {31'd0, bus.in2_ready}, 32'd0);
      end
`else
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checkOutput($sformatf("rot_src_%0d", i), {30'd0, bus.out_src}, i % 3);
         checkOutput($sformatf("rot_data_%0d", i), bus.out_data, rot_data[i % 3]);
         checkOutput($sformatf("rot_valid_%0d", i), {31'd0, bus.out_valid}, 32'd1);
      end

      // Register 0x11 from requester 1, then stall with everyone asking.
      applyStimulus(1'b0, 1'b1, 1'b0, 32'hA0, 32'h11, 32'hC2, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'hA0, 32'h11, 32'hC2, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput($sformatf("stall_readys_%0d", i),
                     {29'd0, bus.in2_ready, bus.in1_ready, bus.in0_ready}, 32'd0);
         checkOutput($sformatf("stall_data_%0d", i), bus.out_data, 32'h11);
         checkOutput($sformatf("stall_src_%0d", i), {30'd0, bus.out_src}, 32'd1);
      end
      applyStimulus(1'b1, 1'b1, 1'b1, 32'hA0, 32'h11, 32'hC2, 1'b1);
      @(negedge clk);
      checkOutput("stall_release_grant",
                  {29'd0, bus.in2_ready, bus.in1_ready, bus.in0_ready}, 32'b100);
      @(negedge clk);
      checkOutput("stall_release_src", {30'd0, bus.out_src}, 32'd2);
      checkOutput("stall_release_data", bus.out_data, 32'hC2);
`endif

      // Let the pipeline empty, then single pulses from 2 and then 0.
      applyStimulus(1'b0, 1'b0, 1'b0, 32'hA0, 32'hB1, 32'hC2, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'hA0, 32'hB1, 32'hC2, 1'b1);
      @(negedge clk);
      checkOutput("idle_drop", {31'd0, bus.out_valid}, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h22, 1'b1);
      @(negedge clk);
      checkOutput("sparse2_ready", {31'd0, bus.in2_ready}, 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
      @(negedge clk);
      checkOutput("sparse2_src", {30'd0, bus.out_src}, 32'd2);
      checkOutput("sparse2_data", bus.out_data, 32'h22);
      checkOutput("sparse2_valid", {31'd0, bus.out_valid}, 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h33, 32'h0, 32'h0, 1'b1);
      @(negedge clk);
      checkOutput("sparse_gap_valid", {31'd0, bus.out_valid}, 32'd0);
      checkOutput("sparse0_ready", {31'd0, bus.in0_ready}, 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
      @(negedge clk);
      checkOutput("sparse0_src", {30'd0, bus.out_src}, 32'd0);
      checkOutput("sparse0_data", bus.out_data, 32'h33);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
      @(negedge clk);
      checkOutput("sparse_end_valid", {31'd0, bus.out_valid}, 32'd0);

      // Fill the register, then pull reset between clock edges.
      applyStimulus(1'b1, 1'b1, 1'b1, 32'hA0, 32'hB1, 32'hC2, 1'b0);
      @(posedge clk);
      #2;
      checkOutput("pre_areset_valid", {31'd0, bus.out_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("areset_valid", {31'd0, bus.out_valid}, 32'd0);
      checkOutput("areset_data", bus.out_data, 32'd0);
      checkOutput("areset_readys", {29'd0, bus.in2_ready, bus.in1_ready, bus.in0_ready}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("restart_grant", {29'd0, bus.in2_ready, bus.in1_ready, bus.in0_ready}, 32'b001);
      @(negedge clk);
      checkOutput("restart_src", {30'd0, bus.out_src}, 32'd0);
      checkOutput("restart_data", bus.out_data, 32'hA0);

      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
